// File: rtl/noc_inj_arbiter_if.sv
// Bundle of request, router-port and control signals of the NoC injection arbiter.
// master: arbiter view; slave: environment view (requesters + router + control).
interface noc_inj_arbiter_if #(
  parameter int REQ_N       = 4,
  parameter int ROW_N       = 3,
  parameter int COL_M       = 3,
  parameter int PCKT_DATA_W = 8
);
  localparam int COL_ADDR_W = $clog2(COL_M);
  localparam int ROW_ADDR_W = $clog2(ROW_N);
  localparam int PCKT_W     = PCKT_DATA_W + ROW_ADDR_W + COL_ADDR_W;

  logic [REQ_N-1:0]             req_valid_i;
  logic [REQ_N*COL_ADDR_W-1:0]  req_col_i;
  logic [REQ_N*ROW_ADDR_W-1:0]  req_row_i;
  logic [REQ_N*PCKT_DATA_W-1:0] req_data_i;
  logic [REQ_N-1:0]             req_ready_o;
  logic [PCKT_W-1:0]            pckt_o;
  logic                         wren_o;
  logic                         noc_full_i;
  logic                         noc_ovrflw_i;
  logic                         flush_i;
  logic                         flush_done_o;
  logic                         ovrflw_err_o;
  logic                         addr_err_o;

  modport master (
    input  req_valid_i, req_col_i, req_row_i, req_data_i,
    input  noc_full_i, noc_ovrflw_i, flush_i,
    output req_ready_o, pckt_o, wren_o, flush_done_o, ovrflw_err_o, addr_err_o
  );

  modport slave (
    output req_valid_i, req_col_i, req_row_i, req_data_i,
    output noc_full_i, noc_ovrflw_i, flush_i,
    input  req_ready_o, pckt_o, wren_o, flush_done_o, ovrflw_err_o, addr_err_o
  );
endinterface

// File: rtl/noc_inj_arbiter.sv
// noc_inj_arbiter: shares one router resource port between REQ_N local requesters.
// Each requester owns a one-entry holding register; a round-robin arbiter writes at
// most one packet every two cycles into the router FIFO, honouring its full flag.
// A flush request drains all holding registers and reports completion.
// Optional build macro INJ_FIXED_PRIO_EN: lowest-index valid buffer always wins,
// round-robin pointer held at 0.
module noc_inj_arbiter #(
  parameter int REQ_N       = 4,
  parameter int ROW_N       = 3,
  parameter int COL_M       = 3,
  parameter int PCKT_DATA_W = 8
) (
  input logic               clk_i,
  input logic               rst_ni,
  noc_inj_arbiter_if.master bus
);

  localparam int COL_ADDR_W = $clog2(COL_M);
  localparam int ROW_ADDR_W = $clog2(ROW_N);
  localparam int PCKT_W     = PCKT_DATA_W + ROW_ADDR_W + COL_ADDR_W;
  localparam int IDX_W      = $clog2(REQ_N);
  localparam int unsigned REQ_NU = REQ_N;
  localparam int unsigned COL_MU = COL_M;
  localparam int unsigned ROW_NU = ROW_N;

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  state_t state, state_nxt;

  logic [REQ_N-1:0]       buf_v;
  logic [COL_ADDR_W-1:0]  buf_col  [REQ_N];
  logic [ROW_ADDR_W-1:0]  buf_row  [REQ_N];
  logic [PCKT_DATA_W-1:0] buf_data [REQ_N];

  logic [IDX_W-1:0]  ptr, ptr_nxt, win;
  logic              issue;
  logic [REQ_N-1:0]  cap, addr_ok, grant;
  logic [REQ_N-1:0]  ready;
  logic              run_en, flush_done;
  logic              wren;
  logic [PCKT_W-1:0] pckt;
  logic              ovrflw_err, addr_err;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= RUN;
    else         state <= state_nxt;
  end

  // Next-state logic: RUN -> DRAIN on flush, DRAIN -> DONE once empty and idle
  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN:     if (bus.flush_i) state_nxt = DRAIN;
      DRAIN:   if (buf_v == '0 && !wren) state_nxt = DONE;
      DONE:    if (!bus.flush_i) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // FSM outputs: captures only in RUN, completion flag in DONE
  always_comb begin
    run_en     = (state == RUN);
    flush_done = (state == DONE);
  end

  // Capture qualification and address range check per requester
  always_comb begin
    ready   = '0;
    cap     = '0;
    addr_ok = '0;
    for (int unsigned i = 0; i < REQ_NU; i++) begin
      ready[i]   = ~buf_v[i] & run_en;
      cap[i]     = bus.req_valid_i[i] & ready[i];
      addr_ok[i] = (32'(bus.req_col_i[i*COL_ADDR_W +: COL_ADDR_W]) < COL_MU) &&
                   (32'(bus.req_row_i[i*ROW_ADDR_W +: ROW_ADDR_W]) < ROW_NU);
    end
  end

  // Winner selection; wren term spaces writes to cover the router full-flag lag
  always_comb begin
    int unsigned idx;
    logic        found;
    idx   = 0;
    found = 1'b0;
    win   = '0;
`ifdef INJ_FIXED_PRIO_EN
    for (int unsigned k = 0; k < REQ_NU; k++) begin
      idx = k;
      if (!found && buf_v[idx]) begin
        win   = IDX_W'(idx);
        found = 1'b1;
      end
    end
`else
    for (int unsigned k = 0; k < REQ_NU; k++) begin
      idx = (32'(ptr) + k) % REQ_NU;
      if (!found && buf_v[idx]) begin
        win   = IDX_W'(idx);
        found = 1'b1;
      end
    end
`endif
    issue = found & ~bus.noc_full_i & ~wren;
    grant = '0;
    if (issue) grant[win] = 1'b1;
  end

  // Pointer update: one past the winner after a grant, otherwise hold
  always_comb begin
    ptr_nxt = ptr;
`ifdef INJ_FIXED_PRIO_EN
    ptr_nxt = '0;
`else
    if (issue) ptr_nxt = (32'(win) == REQ_NU - 1) ? '0 : win + 1'b1;
`endif
  end

  // Datapath: holding registers, packet register, write strobe, sticky errors
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_v      <= '0;
      ptr        <= '0;
      wren       <= 1'b0;
      pckt       <= '0;
      ovrflw_err <= 1'b0;
      addr_err   <= 1'b0;
      for (int unsigned i = 0; i < REQ_NU; i++) begin
        buf_col[i]  <= '0;
        buf_row[i]  <= '0;
        buf_data[i] <= '0;
      end
    end else begin
      wren  <= issue;
      ptr   <= ptr_nxt;
      buf_v <= (buf_v & ~grant) | (cap & addr_ok);
      if (issue) pckt <= {buf_data[win], buf_row[win], buf_col[win]};
      for (int unsigned i = 0; i < REQ_NU; i++) begin
        if (cap[i]) begin
          buf_col[i]  <= bus.req_col_i[i*COL_ADDR_W +: COL_ADDR_W];
          buf_row[i]  <= bus.req_row_i[i*ROW_ADDR_W +: ROW_ADDR_W];
          buf_data[i] <= bus.req_data_i[i*PCKT_DATA_W +: PCKT_DATA_W];
        end
      end
      if (|(cap & ~addr_ok)) addr_err   <= 1'b1;
      if (bus.noc_ovrflw_i)  ovrflw_err <= 1'b1;
    end
  end

  assign bus.req_ready_o  = ready;
  assign bus.pckt_o       = pckt;
  assign bus.wren_o       = wren;
  assign bus.flush_done_o = flush_done;
  assign bus.ovrflw_err_o = ovrflw_err;
  assign bus.addr_err_o   = addr_err;

endmodule

// File: tb/tb_noc_inj_arbiter.sv
// Directed testbench for noc_inj_arbiter (REQ_N=4, 3x3 mesh, 8-bit payload).
// Table of per-cycle vectors plus hand-written backpressure, drain and reset sequences.
module tb_noc_inj_arbiter;
  localparam int REQ_N = 4;
  localparam int ROW_N = 3;
  localparam int COL_M = 3;
  localparam int DW    = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  noc_inj_arbiter_if #(.REQ_N(REQ_N), .ROW_N(ROW_N), .COL_M(COL_M), .PCKT_DATA_W(DW)) bus ();

  noc_inj_arbiter #(.REQ_N(REQ_N), .ROW_N(ROW_N), .COL_M(COL_M), .PCKT_DATA_W(DW)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  valid;
    logic [7:0]  col;
    logic [7:0]  row;
    logic [31:0] data;
    logic        full;
    logic        ovr;
    logic        flush;
    logic        e_wren;
    logic [11:0] e_pckt;
    logic [3:0]  e_ready;
    logic        e_done;
    logic        e_oerr;
    logic        e_aerr;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [NV];

  int n_checks = 0;
  int n_fail   = 0;

  // requester i: col/row/data per i; packets 0:114 1:229 2:332 3:440
  localparam logic [7:0]  C = 8'h24;
  localparam logic [7:0]  R = 8'h09;
  localparam logic [31:0] D = 32'h44332211;

  function automatic vec_t mk(input logic [3:0] v, input logic [7:0] c, input logic [7:0] r,
                              input logic [31:0] d, input logic fl, input logic ov, input logic fs,
                              input logic w, input logic [11:0] p, input logic [3:0] rd,
                              input logic dn, input logic oe, input logic ae);
    vec_t x;
    x.valid = v; x.col = c; x.row = r; x.data = d; x.full = fl; x.ovr = ov; x.flush = fs;
    x.e_wren = w; x.e_pckt = p; x.e_ready = rd; x.e_done = dn; x.e_oerr = oe; x.e_aerr = ae;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] v, input logic [7:0] c, input logic [7:0] r,
                       input logic [31:0] d);
    bus.req_valid_i = v;
    bus.req_col_i   = c;
    bus.req_row_i   = r;
    bus.req_data_i  = d;
  endtask

  task automatic chk_out(input string tag, input logic w, input logic [11:0] p,
                         input logic [3:0] rd, input logic dn);
    chk({tag, ".wren"},  32'(bus.wren_o), 32'(w));
    chk({tag, ".pckt"},  32'(bus.pckt_o), 32'(p));
    chk({tag, ".ready"}, 32'(bus.req_ready_o), 32'(rd));
    chk({tag, ".done"},  32'(bus.flush_done_o), 32'(dn));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    // round-robin from ptr=0 with all four requesters valid
    vecs[0]  = mk(4'hF, C, R, D, 0, 0, 0, 0, 12'h000, 4'b0000, 0, 0, 0);
    vecs[1]  = mk(4'hF, C, R, D, 0, 0, 0, 1, 12'h114, 4'b0001, 0, 0, 0);
    vecs[2]  = mk(4'hF, C, R, D, 0, 0, 0, 0, 12'h114, 4'b0000, 0, 0, 0);
    vecs[3]  = mk(4'hF, C, R, D, 0, 0, 0, 1, 12'h229, 4'b0010, 0, 0, 0);
    vecs[4]  = mk(4'hF, C, R, D, 0, 0, 0, 0, 12'h229, 4'b0000, 0, 0, 0);
    vecs[5]  = mk(4'hF, C, R, D, 0, 0, 0, 1, 12'h332, 4'b0100, 0, 0, 0);
    vecs[6]  = mk(4'hF, C, R, D, 0, 0, 0, 0, 12'h332, 4'b0000, 0, 0, 0);
    vecs[7]  = mk(4'hF, C, R, D, 0, 0, 0, 1, 12'h440, 4'b1000, 0, 0, 0);
    vecs[8]  = mk(4'hF, C, R, D, 0, 0, 0, 0, 12'h440, 4'b0000, 0, 0, 0);
    vecs[9]  = mk(4'hF, C, R, D, 0, 0, 0, 1, 12'h114, 4'b0001, 0, 0, 0);
    // stop requesting: remaining buffers drain 1,2,3
    vecs[10] = mk(4'h0, C, R, D, 0, 0, 0, 0, 12'h114, 4'b0001, 0, 0, 0);
    vecs[11] = mk(4'h0, C, R, D, 0, 0, 0, 1, 12'h229, 4'b0011, 0, 0, 0);
    vecs[12] = mk(4'h0, C, R, D, 0, 0, 0, 0, 12'h229, 4'b0011, 0, 0, 0);
    vecs[13] = mk(4'h0, C, R, D, 0, 0, 0, 1, 12'h332, 4'b0111, 0, 0, 0);
    vecs[14] = mk(4'h0, C, R, D, 0, 0, 0, 0, 12'h332, 4'b0111, 0, 0, 0);
    vecs[15] = mk(4'h0, C, R, D, 0, 0, 0, 1, 12'h440, 4'b1111, 0, 0, 0);
    vecs[16] = mk(4'h0, C, R, D, 0, 0, 0, 0, 12'h440, 4'b1111, 0, 0, 0);
    // single request: requester 2, col=1 row=2 data=A5 -> 12'hA59
    vecs[17] = mk(4'h4, 8'h10, 8'h20, 32'h00A50000, 0, 0, 0, 0, 12'h440, 4'b1011, 0, 0, 0);
    vecs[18] = mk(4'h0, 8'h10, 8'h20, 32'h00A50000, 0, 0, 0, 1, 12'hA59, 4'b1111, 0, 0, 0);
    vecs[19] = mk(4'h0, 8'h10, 8'h20, 32'h00A50000, 0, 0, 0, 0, 12'hA59, 4'b1111, 0, 0, 0);
    // column out of range: dropped, sticky addr error
    vecs[20] = mk(4'h1, 8'h03, 8'h00, 32'h00000077, 0, 0, 0, 0, 12'hA59, 4'b1111, 0, 0, 1);
    vecs[21] = mk(4'h0, 8'h03, 8'h00, 32'h00000077, 0, 0, 0, 0, 12'hA59, 4'b1111, 0, 0, 1);
    // router overflow pulse: sticky
    vecs[22] = mk(4'h0, 8'h00, 8'h00, 32'h0, 0, 1, 0, 0, 12'hA59, 4'b1111, 0, 1, 1);
    vecs[23] = mk(4'h0, 8'h00, 8'h00, 32'h0, 0, 0, 0, 0, 12'hA59, 4'b1111, 0, 1, 1);

    drive(4'h0, 8'h0, 8'h0, 32'h0);
    bus.noc_full_i   = 1'b0;
    bus.noc_ovrflw_i = 1'b0;
    bus.flush_i      = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 1'b0, 12'h000, 4'b1111, 1'b0);
    chk("reset.oerr", 32'(bus.ovrflw_err_o), 32'd0);
    chk("reset.aerr", 32'(bus.addr_err_o), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].valid, vecs[i].col, vecs[i].row, vecs[i].data);
      bus.noc_full_i   = vecs[i].full;
      bus.noc_ovrflw_i = vecs[i].ovr;
      bus.flush_i      = vecs[i].flush;
      tick();
      chk_out($sformatf("vec%0d", i), vecs[i].e_wren, vecs[i].e_pckt, vecs[i].e_ready,
              vecs[i].e_done);
      chk($sformatf("vec%0d.oerr", i), 32'(bus.ovrflw_err_o), 32'(vecs[i].e_oerr));
      chk($sformatf("vec%0d.aerr", i), 32'(bus.addr_err_o), 32'(vecs[i].e_aerr));
    end

    // sticky errors cleared only by reset; then row out of range on requester 1
    bus.noc_ovrflw_i = 1'b0;
    do_reset();
    chk("rst2.aerr", 32'(bus.addr_err_o), 32'd0);
    chk("rst2.oerr", 32'(bus.ovrflw_err_o), 32'd0);
    drive(4'h2, 8'h00, 8'h0C, 32'h0);
    tick();
    chk("rowerr.aerr", 32'(bus.addr_err_o), 32'd1);
    chk("rowerr.ready", 32'(bus.req_ready_o), 32'hF);
    drive(4'h0, 8'h00, 8'h00, 32'h0);
    tick();
    chk("rowerr.wren", 32'(bus.wren_o), 32'd0);
    do_reset();

    // backpressure: 3 buffers held 5 cycles, then issued on cycles 1,3,5
    bus.noc_full_i = 1'b1;
    drive(4'h7, C, R, D);
    tick();
    chk_out("bp.load", 1'b0, 12'h000, 4'b1000, 1'b0);
    drive(4'h0, C, R, D);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_out($sformatf("bp.stall%0d", i), 1'b0, 12'h000, 4'b1000, 1'b0);
    end
    bus.noc_full_i = 1'b0;
    tick(); chk_out("bp.c1", 1'b1, 12'h114, 4'b1001, 1'b0);
    tick(); chk_out("bp.c2", 1'b0, 12'h114, 4'b1001, 1'b0);
    tick(); chk_out("bp.c3", 1'b1, 12'h229, 4'b1011, 1'b0);
    tick(); chk_out("bp.c4", 1'b0, 12'h229, 4'b1011, 1'b0);
    tick(); chk_out("bp.c5", 1'b1, 12'h332, 4'b1111, 1'b0);
    tick(); chk_out("bp.c6", 1'b0, 12'h332, 4'b1111, 1'b0);

    // drain: ptr=3 so search wraps to 0 then 1; captures blocked while draining
    bus.noc_full_i = 1'b1;
    drive(4'h3, C, R, D);
    tick(); chk_out("dr.load", 1'b0, 12'h332, 4'b1100, 1'b0);
    bus.noc_full_i = 1'b0;
    drive(4'h0, C, R, D);
    bus.flush_i = 1'b1;
    tick(); chk_out("dr.e1", 1'b1, 12'h114, 4'b0000, 1'b0);
    drive(4'hF, C, R, D);
    tick(); chk_out("dr.e2", 1'b0, 12'h114, 4'b0000, 1'b0);
    tick(); chk_out("dr.e3", 1'b1, 12'h229, 4'b0000, 1'b0);
    tick(); chk_out("dr.e4", 1'b0, 12'h229, 4'b0000, 1'b0);
    tick(); chk_out("dr.e5", 1'b0, 12'h229, 4'b0000, 1'b1);
    bus.flush_i = 1'b0;
    drive(4'h0, C, R, D);
    tick(); chk_out("dr.run", 1'b0, 12'h229, 4'b1111, 1'b0);

    // mid-operation reset with 3 buffers held; ptr was 2 before reset
    bus.noc_full_i = 1'b1;
    drive(4'h7, C, R, D);
    tick();
    drive(4'h0, C, R, D);
    bus.noc_ovrflw_i = 1'b1;
    tick();
    bus.noc_ovrflw_i = 1'b0;
    chk("mr.pre_oerr", 32'(bus.ovrflw_err_o), 32'd1);
    chk("mr.pre_ready", 32'(bus.req_ready_o), 32'h8);
    rst_n = 1'b0;
    #1;
    chk_out("mr.async", 1'b0, 12'h000, 4'b1111, 1'b0);
    chk("mr.oerr", 32'(bus.ovrflw_err_o), 32'd0);
    tick();
    rst_n = 1'b1;
    bus.noc_full_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out($sformatf("mr.idle%0d", i), 1'b0, 12'h000, 4'b1111, 1'b0);
    end
    drive(4'hF, C, R, D);
    tick();
    drive(4'h0, C, R, D);
    tick();
    chk_out("mr.ptr0", 1'b1, 12'h114, 4'b0001, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/noc_inj_arbiter.md
# noc_inj_arbiter

Injection arbiter that shares one resource input channel of the mesh NoC between REQ_N local requesters. It captures each requester's (column, row, data) request into a per-requester holding register, assembles the packet, and writes it into the router's resource FIFO. It uses round-robin arbitration and respects the router's full flag. A drain sequence lets software quiesce the node before reconfiguration.

## Interface
- REQ_N, 4, number of local requesters (2..8)
- ROW_N, 3, mesh rows
- COL_M, 3, mesh columns
- PCKT_DATA_W, 8, packet payload width
- Derived widths:
  - COL_ADDR_W = $clog2(COL_M)
  - ROW_ADDR_W = $clog2(ROW_N)
  - PCKT_W = PCKT_DATA_W + ROW_ADDR_W + COL_ADDR_W
- Ports:
  - clk_i  in  1  clock; single clock domain, rising edge
  - rst_ni  in  1  asynchronous active-low reset
  - req_valid_i  in  REQ_N  request valid, one bit per requester
  - req_col_i  in  REQ_N*COL_ADDR_W  destination column; requester i at slice [i*COL_ADDR_W +: COL_ADDR_W]
  - req_row_i  in  REQ_N*ROW_ADDR_W  destination row, same slicing scheme
  - req_data_i  in  REQ_N*PCKT_DATA_W  payload, same slicing scheme
  - req_ready_o  out  REQ_N  holding register i is empty
  - pckt_o  out  PCKT_W  packet to the router resource port
  - wren_o  out  1  router resource FIFO write enable
  - noc_full_i  in  1  router resource FIFO full
  - noc_ovrflw_i  in  1  router resource FIFO overflow
  - flush_i  in  1  start a drain (level; sampled while in RUN)
  - flush_done_o  out  1  drain complete
  - ovrflw_err_o  out  1  sticky: router reported overflow
  - addr_err_o  out  1  sticky: an out-of-range address was dropped

## Operation
- Packet format: pckt_o = {data, row, col}, with col in the LSBs.
- Capture:
  - A request is captured when req_valid_i[i] & req_ready_o[i] on a rising edge.
  - A captured request sets buf_v[i].
  - req_ready_o[i] = ~buf_v[i] & (state == RUN).
- Address check:
  - If the captured col ≥ COL_M or row ≥ ROW_N, the entry is not stored.
  - buf_v[i] stays 0 and addr_err_o sets.
- Issue condition, evaluated each cycle: any buf_v set, noc_full_i = 0, and wren_o = 0.
  - The wren_o = 0 term limits writes to at most one every two cycles. This covers the one-cycle lag of the router's full flag, so the arbiter never overflows a correctly behaving FIFO.
- Issue action:
  - Select winner w.
  - On the next edge, register pckt_o from buffer w, set wren_o = 1, clear buf_v[w].
  - If w also has a new capture in the same edge, the capture is blocked because ready was 0.
- Round-robin:
  - The search starts at index ptr and wraps modulo REQ_N.
  - After a grant, ptr = (w+1) mod REQ_N; otherwise ptr holds.
- wren_o is high for exactly one cycle per packet.
- pckt_o holds its last value when wren_o = 0.
- noc_ovrflw_i high on any edge sets ovrflw_err_o. Only reset clears either sticky error.
- FSM states:
  - RUN: normal operation. flush_i = 1 → DRAIN.
  - DRAIN: no captures. Issuing continues. When all buf_v = 0 and wren_o = 0 → DONE.
  - DONE: flush_done_o = 1, no captures. flush_i = 0 → RUN.
- Reset: asynchronous. An assertion mid-operation discards all buffered requests immediately.

## Timing
- Reset values:
  - pckt_o = 0, wren_o = 0, req_ready_o = all ones (state RUN, buf_v = 0)
  - flush_done_o = 0, ovrflw_err_o = 0, addr_err_o = 0, ptr = 0
- Latency: a capture on edge N gives wren_o = 1 after edge N+1 at the earliest (one cycle in the buffer).
- Throughput: one packet per two cycles maximum.
- A requester refills its buffer on the edge after the grant edge, so each requester sustains one packet per two cycles.
- noc_full_i is sampled combinationally in the cycle before the write edge. Full = 1 for k cycles stalls issue for k cycles; buffers and ptr hold.
- The flush_i → DRAIN transition takes effect on the next edge. A capture that coincides with that edge is still accepted and is drained.
- If buffers are empty, DONE is reached 2 edges after flush_i is sampled.

## Configuration
- INJ_FIXED_PRIO_EN:
  - Defined: fixed priority; the lowest-index valid buffer always wins and ptr is unused, held at 0.
  - Undefined (default): round-robin as in Operation.

## Test plan
- Single request: requester 2 sends col=1, row=2, data=0xA5 → one cycle later, wren_o = 1 for 1 cycle with pckt_o = {0xA5, 2'd2, 2'd1} = 12'hA59, and req_ready_o[2] returns to 1.
- Round-robin: all 4 requesters valid continuously, no full → grant order 0,1,2,3,0,…, with wren_o on alternate cycles and no requester starved. With INJ_FIXED_PRIO_EN, requester 0 wins every grant.
- Backpressure: noc_full_i = 1 for 5 cycles while 3 buffers are valid → wren_o stays 0 and ptr holds. Release → 3 packets issue in order on cycles 1, 3, 5.
- Address error: col=3 with COL_M=3 → not buffered, addr_err_o = 1 thereafter, no wren_o. noc_ovrflw_i pulsed for 1 cycle → ovrflw_err_o = 1 until reset.
- Drain: 2 buffers valid, flush_i = 1 → req_ready_o = 0, 2 packets issue, then flush_done_o = 1. flush_i = 0 → RUN, req_ready_o = all ones.
- Mid-operation reset: rst_ni low with 3 buffers valid → outputs go to reset values immediately, no wren_o after release, and ptr restarts at 0.
